data_memory: RTL and testbench
==============================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter LATENCY, default 10, clock edges from request acceptance to ready assertion.
REQ-002 SHALL have parameter DEPTH, default 512, number of storage lines.
REQ-003 SHALL have parameter LINE_W, default 256, bits per line.
REQ-004 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_i  input  1  reset; asynchronous, active-high.
REQ-006 DDATA_ren  input  1  read request; held high by the master until ready is seen.
REQ-007 DDATA_wen  input  1  write request; held high by the master until ready is seen.
REQ-008 DDATA_addr  input  27  line (block) address; only bits [log2(DEPTH)-1:0] are used.
REQ-009 DDATA_wdata  input  LINE_W  write line data.
REQ-010 DDATA_rdata  output  LINE_W  read line data; registered; valid while DDATA_ready=1.
REQ-011 DDATA_ready  output  1  one-cycle completion pulse for the accepted request.

Function
REQ-012 SHALL hold storage as DEPTH x LINE_W bits, indexed by DDATA_addr[8:0] (default DEPTH); upper address bits are ignored, so address 0x200 aliases line 0.
REQ-013 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-014 In IDLE, a rising edge with ren|wen=1 SHALL accept the request, latch addr, wdata and the op, clear the counter to 0, and go to BUSY; otherwise the FSM stays in IDLE.
REQ-015 If ren and wen are both high at acceptance, the op SHALL be a write.
REQ-016 In BUSY, the counter SHALL increment on each edge; inputs SHALL be ignored (latched values are used).
REQ-017 On the LATENCY-th rising edge after the accepting edge, the FSM SHALL enter DONE and drive DDATA_ready=1.
REQ-018 On that same edge, a read SHALL drive DDATA_rdata=mem[latched addr] and a write SHALL update mem[latched addr]=latched wdata.
REQ-019 On a write completion, DDATA_rdata SHALL take the written data.
REQ-020 From DONE, the next edge SHALL clear DDATA_ready and return the FSM to IDLE without accepting a request on that edge.
REQ-021 The earliest next acceptance SHALL be the edge after DONE, giving a minimum period of LATENCY+2 edges per request.
REQ-022 DDATA_rdata SHALL hold its last value after ready falls, until the next completion.
REQ-023 Storage SHALL be hierarchically accessible as an array named memory, so a bench can preload and peek lines.
REQ-024 The counter SHALL be wide enough for LATENCY and SHALL NOT wrap during a request.

Reset
REQ-025 While rst_i=1, asynchronously: FSM=IDLE, counter=0, DDATA_ready=0, DDATA_rdata=0, latched op/addr/wdata cleared.
REQ-026 Memory contents SHALL NOT be affected by reset.
REQ-027 Reset during BUSY SHALL abandon the request: no write is performed and no ready pulse occurs.
REQ-028 After rst_i falls, the first rising edge with a request SHALL be accepted normally.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE/BUSY/DONE), LINE_W=256, ADDR_W=27 and the default LATENCY constant.
REQ-030 The design SHALL be a single module with no sub-modules; the storage array is inferred in-module.

Verification
REQ-031 Preload memory[0]=0x5, read addr 0 -> ready high exactly 10 edges after acceptance for 1 cycle, rdata=0x...05 (256-bit).
REQ-032 Write addr 3 with data 0xDEADBEEF, then read addr 3 -> the write ready pulse comes after 10 edges; the read returns 0x...DEADBEEF; no other line changes.
REQ-033 ren=wen=1, addr 7, wdata 0xA5 -> treated as a write; memory[7]=0xA5; rdata=0xA5 at ready.
REQ-034 Read addr 0x200 with memory[0]=0x5 -> rdata=0x5 (aliasing).
REQ-035 Assert rst_i at edge 5 of a write to addr 2 -> no ready pulse, memory[2] unchanged, rdata=0; a request after reset completes in 10 edges.
REQ-036 Hold ren high continuously -> ready pulses every 12 edges, never on consecutive cycles.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Shared types and constants for the fixed-latency line data memory.
// Holds the request FSM state encoding and default geometry/latency.
// Imported by the data_memory top.
package data_memory_pkg;

  // Request handshake FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int LINE_W          = 256;
  localparam int ADDR_W          = 27;
  localparam int DEFAULT_LATENCY = 10;
  localparam int DEFAULT_DEPTH   = 512;

endpackage

// File: rtl/data_memory.sv
// Line-organised data memory: one read or write per request, write wins if both requested.
// Latency: DDATA_ready pulses LATENCY edges after acceptance; one idle edge follows (LATENCY+2 per request).
// Backpressure: master holds ren/wen until ready; requests are ignored while BUSY or DONE.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LINE_W  = data_memory_pkg::LINE_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              DDATA_ren,
  input  logic              DDATA_wen,
  input  logic [26:0]       DDATA_addr,
  input  logic [LINE_W-1:0] DDATA_wdata,
  output logic [LINE_W-1:0] DDATA_rdata,
  output logic              DDATA_ready
);

  localparam int AW    = $clog2(DEPTH);
  // Counter must be able to hold LATENCY itself, since it also steps on the completing edge
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  // Storage; deliberately has no reset so contents survive rst_i
  logic [LINE_W-1:0] memory [DEPTH];

  state_t            state;
  state_t            state_n;
  logic [CNT_W-1:0]  cnt;
  logic              op_wr;
  logic [AW-1:0]     addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              accept;
  logic              finish;

  // Upper line-address bits select nothing: addresses alias modulo DEPTH
  logic unused_addr_bits;
  assign unused_addr_bits = ^DDATA_addr[ADDR_W-1:AW];

  assign accept      = (state == IDLE) && (DDATA_ren || DDATA_wen);
  assign finish      = (state == BUSY) && (cnt == CNT_LAST);
  assign DDATA_ready = (state == DONE);

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state: accept in IDLE, count out the latency in BUSY, one DONE cycle, then back to IDLE
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (DDATA_ren || DDATA_wen) state_n = BUSY;
      BUSY:    if (cnt == CNT_LAST)         state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Request latch, latency counter and registered read data
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt         <= '0;
      op_wr       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      DDATA_rdata <= '0;
    end else begin
      if (accept) begin
        cnt     <= '0;
        op_wr   <= DDATA_wen;
        addr_q  <= DDATA_addr[AW-1:0];
        wdata_q <= DDATA_wdata;
      end else if (state == BUSY) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (finish) begin
        DDATA_rdata <= op_wr ? wdata_q : memory[addr_q];
      end
    end
  end

  // Line write at completion; FSM reset to IDLE blocks an abandoned write
  always_ff @(posedge clk_i) begin
    if (finish && op_wr) begin
      memory[addr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus randomized traffic.
// Expected data comes from a line-array model; expected timing from the request rules.
// Inputs driven at the falling edge, outputs sampled at the falling edge.
module tb_data_memory;

  localparam int LW  = 256;
  localparam int DEP = 512;
  localparam int LAT = 10;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          DDATA_ren;
  logic          DDATA_wen;
  logic [26:0]   DDATA_addr;
  logic [LW-1:0] DDATA_wdata;
  logic [LW-1:0] DDATA_rdata;
  logic          DDATA_ready;

  logic [LW-1:0] ref_mem [DEP];
  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  data_memory #(.LATENCY(LAT), .DEPTH(DEP), .LINE_W(LW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .DDATA_ren   (DDATA_ren),
    .DDATA_wen   (DDATA_wen),
    .DDATA_addr  (DDATA_addr),
    .DDATA_wdata (DDATA_wdata),
    .DDATA_rdata (DDATA_rdata),
    .DDATA_ready (DDATA_ready)
  );

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Model: a write (or both) stores the data and returns it; a read returns the stored line
  function automatic logic [LW-1:0] model_op(input logic r, input logic w,
                                              input logic [26:0] a, input logic [LW-1:0] d);
    int idx;
    idx = int'(a) % DEP;
    if (w) begin
      ref_mem[idx] = d;
      return d;
    end
    if (r) return ref_mem[idx];
    return '0;
  endfunction

  // Issue one request from a falling edge with the DUT idle; returns edges-to-ready and rdata.
  // Ends on the falling edge after the DONE->IDLE edge.
  task automatic do_req(input logic r, input logic w, input logic [26:0] a,
                        input logic [LW-1:0] d, output int lat, output logic [LW-1:0] rd);
    bit seen;
    DDATA_ren = r; DDATA_wen = w; DDATA_addr = a; DDATA_wdata = d;
    @(posedge clk_i);
    lat = -1; rd = '0; seen = 0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (DDATA_ready) begin
        lat = n; rd = DDATA_rdata; seen = 1;
      end
    end
    DDATA_ren = 1'b0; DDATA_wen = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (DDATA_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_pulse_width: ready=%b after pulse, expected 0", DDATA_ready);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; DDATA_ren = 0; DDATA_wen = 0; DDATA_addr = '0; DDATA_wdata = '0;
    for (int i = 0; i < DEP; i++) begin
      ref_mem[i] = rand_line();
      dut.memory[i] = ref_mem[i];
    end
    repeat (3) @(negedge clk_i);
    checks++;
    if (DDATA_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b expected 0", DDATA_ready);
    end
    checks++;
    if (DDATA_rdata !== '0) begin
      errors++; $display("FAIL reset_rdata: got %h expected 0", DDATA_rdata);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_preload_read();
    int lat; logic [LW-1:0] rd, exp;
    ref_mem[0] = 256'h5;
    dut.memory[0] = 256'h5;
    exp = model_op(1, 0, 27'd0, '0);
    do_req(1, 0, 27'd0, rand_line(), lat, rd);
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL read_latency: got %0d expected %0d", lat, LAT); end
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL read_data: got %h expected %h", rd, exp); end
  endtask

  task automatic test_write_read();
    int lat; int mism; logic [LW-1:0] rd, exp;
    exp = model_op(0, 1, 27'd3, 256'hDEADBEEF);
    do_req(0, 1, 27'd3, 256'hDEADBEEF, lat, rd);
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL write_latency: got %0d expected %0d", lat, LAT); end
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL write_rdata: got %h expected %h", rd, exp); end
    exp = model_op(1, 0, 27'd3, '0);
    do_req(1, 0, 27'd3, '0, lat, rd);
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL write_readback: got %h expected %h", rd, exp); end
    mism = 0;
    for (int i = 0; i < DEP; i++) if (dut.memory[i] !== ref_mem[i]) mism++;
    checks++;
    if (mism != 0) begin errors++; $display("FAIL write_isolation: %0d lines differ, expected 0", mism); end
  endtask

  task automatic test_both_is_write();
    int lat; logic [LW-1:0] rd, exp;
    exp = model_op(1, 1, 27'd7, 256'hA5);
    do_req(1, 1, 27'd7, 256'hA5, lat, rd);
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL both_rdata: got %h expected %h", rd, exp); end
    checks++;
    if (dut.memory[7] !== 256'hA5) begin
      errors++; $display("FAIL both_mem: got %h expected a5", dut.memory[7]);
    end
  endtask

  task automatic test_alias();
    int lat; logic [LW-1:0] rd, exp;
    ref_mem[0] = 256'h5;
    dut.memory[0] = 256'h5;
    exp = model_op(1, 0, 27'h200, '0);
    do_req(1, 0, 27'h200, '0, lat, rd);
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL alias_rdata: got %h expected %h", rd, exp); end
  endtask

  task automatic test_random();
    int lat; int op; int bad_lat; int bad_dat; logic [26:0] a; logic [LW-1:0] d, rd, exp;
    int mism;
    bad_lat = 0; bad_dat = 0;
    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 2);
      a  = 27'($urandom);
      if (k % 3 == 0) a = 27'($urandom_range(0, 15));
      d  = rand_line();
      exp = model_op(op != 1, op != 0, a, d);
      do_req(op != 1, op != 0, a, d, lat, rd);
      checks++;
      if (lat !== LAT) begin
        bad_lat++; errors++;
        $display("FAIL rand_latency[%0d]: got %0d expected %0d", k, lat, LAT);
      end
      checks++;
      if (rd !== exp) begin
        bad_dat++; errors++;
        $display("FAIL rand_rdata[%0d]: got %h expected %h", k, rd, exp);
      end
    end
    mism = 0;
    for (int i = 0; i < DEP; i++) if (dut.memory[i] !== ref_mem[i]) mism++;
    checks++;
    if (mism != 0) begin errors++; $display("FAIL rand_memory: %0d lines differ, expected 0", mism); end
  endtask

  task automatic test_reset_busy();
    int lat; bit saw; logic [LW-1:0] old, rd, exp;
    old = ref_mem[2];
    saw = 0;
    DDATA_wen = 1; DDATA_ren = 0; DDATA_addr = 27'd2; DDATA_wdata = ~old;
    @(posedge clk_i);
    repeat (5) begin
      @(negedge clk_i);
      if (DDATA_ready) saw = 1;
      @(posedge clk_i);
    end
    #1 rst_i = 1'b1;
    DDATA_wen = 0;
    repeat (3) begin
      @(negedge clk_i);
      if (DDATA_ready) saw = 1;
    end
    rst_i = 1'b0;
    repeat (15) begin
      @(negedge clk_i);
      if (DDATA_ready) saw = 1;
    end
    checks++;
    if (saw) begin errors++; $display("FAIL rst_busy_ready: pulse seen=%b expected 0", saw); end
    checks++;
    if (dut.memory[2] !== old) begin
      errors++; $display("FAIL rst_busy_mem: got %h expected %h", dut.memory[2], old);
    end
    checks++;
    if (DDATA_rdata !== '0) begin
      errors++; $display("FAIL rst_busy_rdata: got %h expected 0", DDATA_rdata);
    end
    exp = model_op(1, 0, 27'd2, '0);
    do_req(1, 0, 27'd2, '0, lat, rd);
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL post_rst_latency: got %0d expected %0d", lat, LAT); end
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL post_rst_rdata: got %h expected %h", rd, exp); end
  endtask

  task automatic test_back_to_back();
    int pulses[$]; logic [26:0] a; logic [LW-1:0] exp; int bad;
    a = 27'($urandom_range(0, DEP - 1));
    exp = model_op(1, 0, a, '0);
    bad = 0;
    DDATA_ren = 1; DDATA_wen = 0; DDATA_addr = a;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (DDATA_ready) begin
        pulses.push_back(c);
        if (DDATA_rdata !== exp) bad++;
      end
    end
    DDATA_ren = 0;
    repeat (15) @(negedge clk_i);
    checks++;
    if (pulses.size() != 6) begin
      errors++; $display("FAIL b2b_count: got %0d pulses expected 6", pulses.size());
    end
    checks++;
    if (pulses.size() == 0 || pulses[0] != LAT) begin
      errors++; $display("FAIL b2b_first: got %0d expected %0d", (pulses.size() > 0) ? pulses[0] : -1, LAT);
    end
    for (int i = 1; i < pulses.size(); i++) begin
      checks++;
      if (pulses[i] - pulses[i-1] != LAT + 2) begin
        errors++;
        $display("FAIL b2b_period[%0d]: got %0d expected %0d", i, pulses[i] - pulses[i-1], LAT + 2);
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL b2b_rdata: %0d pulses with wrong data, expected 0", bad); end
  endtask

  initial begin
    test_reset();
    @(negedge clk_i);
    test_preload_read();
    test_write_read();
    test_both_is_write();
    test_alias();
    test_random();
    test_reset_busy();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
